// File: rtl/fifo_rd_stream_adapter.sv
// Turns the async FIFO read port (empty / rd_en / rd_data one cycle later) into a registered valid/ready stream.
// Optional saturating accepted-word counter: define RD_ADAPT_XFER_CNT_EN.
module fifo_rd_stream_adapter #(
  parameter int d_width   = 16,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [d_width-1:0]             fifo_rd_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [d_width-1:0]             m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occ,
  output logic [CNT_W-1:0]               xfer_cnt
);
  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CRED_W = OCC_W + 1;

  logic [d_width-1:0] buf_r [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_nx_s;
  logic [OCC_W-1:0]   occ_r;
  logic [OCC_W-1:0]   occ_after_pop_s;
  logic [OCC_W-1:0]   occ_nx_s;
  logic [CRED_W-1:0]  credit_s;
  logic               inflight_r;
  logic               m_valid_r;
  logic [d_width-1:0] m_data_r;
  logic [d_width-1:0] head_nx_s;
  logic               pop_s;
  logic               rd_en_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Read issue, occupancy update and the next head word.
  always_comb begin
    pop_s           = m_valid_r & m_ready;
    credit_s        = CRED_W'(occ_r) + CRED_W'(inflight_r);
    rd_en_s         = ~Reset & ~fifo_empty & ((credit_s < CRED_W'(BUF_DEPTH)) | pop_s);
    rd_ptr_nx_s     = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    occ_after_pop_s = occ_r - OCC_W'(pop_s);
    occ_nx_s        = occ_after_pop_s + OCC_W'(inflight_r);
    // A word landing in an otherwise empty buffer becomes the head directly.
    head_nx_s       = (inflight_r && (occ_after_pop_s == {OCC_W{1'b0}})) ?
                      fifo_rd_data : buf_r[rd_ptr_nx_s];
  end

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign occ        = occ_r;

  // Control state and the registered stream outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      occ_r      <= {OCC_W{1'b0}};
      inflight_r <= 1'b0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      m_valid_r  <= 1'b0;
      m_data_r   <= {d_width{1'b0}};
    end else begin
      inflight_r <= rd_en_s;
      occ_r      <= occ_nx_s;
      rd_ptr_r   <= rd_ptr_nx_s;
      if (inflight_r) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      m_valid_r  <= (occ_nx_s != {OCC_W{1'b0}});
      m_data_r   <= head_nx_s;
    end
  end

  // Skid storage: returning FIFO data is written at the write pointer.
  always_ff @(posedge Clk) begin
    if (inflight_r && !Reset) begin
      buf_r[wr_ptr_r] <= fifo_rd_data;
    end
  end

`ifdef RD_ADAPT_XFER_CNT_EN
  logic [CNT_W-1:0] xfer_cnt_r;

  // Saturating count of accepted words; cleared only by Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      xfer_cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s && (xfer_cnt_r != {CNT_W{1'b1}})) begin
      xfer_cnt_r <= xfer_cnt_r + CNT_W'(1);
    end
  end

  assign xfer_cnt = xfer_cnt_r;
`else
  assign xfer_cnt = {CNT_W{1'b0}};
`endif

endmodule
